// File: rtl/delay_timer_pkg.sv
// Shared defaults and types for the multi-channel delay timer.
package delay_timer_pkg;

  localparam int unsigned DT_NCH            = 4;
  localparam int unsigned DT_CBITS          = 14;
  localparam int unsigned DT_DEFAULT_PERIOD = 15000;

  typedef logic [DT_CBITS-1:0] cnt_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// One delay-timer channel: programmable period, terminal-count tick, window and sticky error.
// Optional one-shot mode is compiled in with DELAY_ONESHOT_EN.
module delay_timer_chan
  import delay_timer_pkg::*;
#(
  parameter int unsigned CBITS          = DT_CBITS,
  parameter int unsigned DEFAULT_PERIOD = DT_DEFAULT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             cfg_we_i,
  input  logic [CBITS-1:0] cfg_period_i,
  input  logic             err_clr_i,
`ifdef DELAY_ONESHOT_EN
  input  logic             oneshot_i,
`endif
  output logic             tick_o,
  output logic             in_win_o,
  output logic             err_o
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] period_q, period_d;
  logic             tick_q, tick_d;
  logic             in_win_q, in_win_d;
  logic             err_q, err_d;
  logic             term_c;
  logic             hold_c;
  logic             err_set_c;

  assign term_c = (cnt_q == period_q);

`ifdef DELAY_ONESHOT_EN
  // Halted after a one-shot tick until en drops or oneshot is cleared.
  logic halt_q, halt_d;

  assign hold_c = oneshot_i & halt_q;
  assign halt_d = en_i & oneshot_i & (halt_q | term_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  assign hold_c = 1'b0;
`endif

  always_comb begin
    cnt_d     = '0;
    tick_d    = 1'b0;
    err_set_c = 1'b0;
    if (en_i && !hold_c) begin
      if (term_c) begin
        tick_d = 1'b1;
      end else if (cnt_q < period_q) begin
        cnt_d = cnt_q + CBITS'(1);
      end else begin
        err_set_c = 1'b1;
      end
    end
    // Window uses the period in effect this cycle, not a pending write.
    in_win_d = (cnt_d <= period_q);
    err_d    = err_set_c | (err_q & ~err_clr_i);
    period_d = cfg_we_i ? cfg_period_i : period_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= CBITS'(DEFAULT_PERIOD);
      tick_q   <= 1'b0;
      in_win_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      in_win_q <= in_win_d;
      err_q    <= err_d;
    end
  end

  assign tick_o   = tick_q;
  assign in_win_o = in_win_q;
  assign err_o    = err_q;

endmodule

// File: rtl/multi_delay_timer.sv
// NCH-channel programmable delay timer; decodes cfg_ch into per-channel period writes.
// Optional one-shot mode (oneshot_i port) is compiled in with DELAY_ONESHOT_EN.
module multi_delay_timer
  import delay_timer_pkg::*;
#(
  parameter  int unsigned NCH            = DT_NCH,
  parameter  int unsigned CBITS          = DT_CBITS,
  parameter  int unsigned DEFAULT_PERIOD = DT_DEFAULT_PERIOD,
  localparam int unsigned CHW            = sel_bits(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en_i,
  input  logic             cfg_we_i,
  input  logic [CHW-1:0]   cfg_ch_i,
  input  logic [CBITS-1:0] cfg_period_i,
  input  logic [NCH-1:0]   err_clr_i,
`ifdef DELAY_ONESHOT_EN
  input  logic [NCH-1:0]   oneshot_i,
`endif
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   in_win_o,
  output logic [NCH-1:0]   err_o
);

  logic [NCH-1:0] ch_we_c;

  // Indices with no matching channel simply produce no write.
  always_comb begin
    ch_we_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cfg_we_i && (cfg_ch_i == CHW'(k))) begin
        ch_we_c[k] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    delay_timer_chan #(
      .CBITS          (CBITS),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en_i[gi]),
      .cfg_we_i     (ch_we_c[gi]),
      .cfg_period_i (cfg_period_i),
      .err_clr_i    (err_clr_i[gi]),
`ifdef DELAY_ONESHOT_EN
      .oneshot_i    (oneshot_i[gi]),
`endif
      .tick_o       (tick_o[gi]),
      .in_win_o     (in_win_o[gi]),
      .err_o        (err_o[gi])
    );
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Self-checking bench for multi_delay_timer: directed table, corner sequences, random vs. model.
// Exercises one-shot mode too when DELAY_ONESHOT_EN is defined.
module tb_multi_delay_timer;
  import delay_timer_pkg::*;

  localparam int NCH = 4;
  localparam int DP  = 15000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  cnt_t       cfg_period;
  logic [3:0] err_clr;
  logic [3:0] oneshot;
  logic [3:0] tick, in_win, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_delay_timer dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_period_i (cfg_period),
    .err_clr_i    (err_clr),
`ifdef DELAY_ONESHOT_EN
    .oneshot_i    (oneshot),
`endif
    .tick_o       (tick),
    .in_win_o     (in_win),
    .err_o        (err)
  );

  // Reference model state
  int         m_cnt [NCH];
  int         m_per [NCH];
  logic [3:0] m_tick, m_win, m_err, m_halt;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Channel behaviour from the rules: count to period, tick at terminal, error beyond it.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int old_per;
      bit set;
      old_per = m_per[c];
      set     = 1'b0;
      if (rst) begin
        m_cnt[c]  = 0;
        m_per[c]  = DP;
        m_tick[c] = 1'b0;
        m_win[c]  = 1'b1;
        m_err[c]  = 1'b0;
        m_halt[c] = 1'b0;
      end else begin
        m_tick[c] = 1'b0;
        if (!en[c]) begin
          m_cnt[c]  = 0;
          m_halt[c] = 1'b0;
        end else if (oneshot[c] && m_halt[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] == old_per) begin
          m_cnt[c]  = 0;
          m_tick[c] = 1'b1;
          m_halt[c] = oneshot[c];
        end else if (m_cnt[c] < old_per) begin
          m_cnt[c] = m_cnt[c] + 1;
        end else begin
          m_cnt[c] = 0;
          set      = 1'b1;
        end
        if (!oneshot[c]) m_halt[c] = 1'b0;
        m_win[c] = (m_cnt[c] <= old_per);
        if (set) m_err[c] = 1'b1;
        else if (err_clr[c]) m_err[c] = 1'b0;
        if (cfg_we && int'(cfg_ch) == c) m_per[c] = int'(cfg_period);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_tick", tick, m_tick);
    check("model_in_win", in_win, m_win);
    check("model_err", err, m_err);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; err_clr = '0;
  endtask

  task automatic write_period(input int ch, input int per);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = cnt_t'(per);
    step();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    int         per;
    logic [3:0] clr;
    logic [3:0] e_tick;
    logic [3:0] e_win;
    logic [3:0] e_err;
  } vec_t;

  vec_t vt [16];

  initial begin
    int first_t, second_t, n_t, other_t;

    rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; err_clr = '0; oneshot = '0;

    vt[0]  = '{1'b1, 4'h0, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[1]  = '{1'b0, 4'h0, 1'b1, 2'd0, 2, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[2]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[3]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[4]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h1, 4'hF, 4'h0};
    vt[5]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[6]  = '{1'b0, 4'h1, 1'b1, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[7]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h1};
    vt[8]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h1, 4'h1, 4'hF, 4'h0};
    vt[9]  = '{1'b0, 4'h1, 1'b0, 2'd0, 0, 4'h0, 4'h1, 4'hF, 4'h0};
    vt[10] = '{1'b0, 4'h0, 1'b0, 2'd0, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[11] = '{1'b0, 4'h2, 1'b1, 2'd1, 0, 4'h0, 4'h0, 4'hF, 4'h0};
    vt[12] = '{1'b0, 4'h2, 1'b0, 2'd0, 0, 4'h2, 4'h0, 4'hF, 4'h2};
    vt[13] = '{1'b0, 4'h2, 1'b0, 2'd0, 0, 4'h0, 4'h2, 4'hF, 4'h2};
    vt[14] = '{1'b0, 4'h0, 1'b0, 2'd0, 0, 4'h2, 4'h0, 4'hF, 4'h0};
    vt[15] = '{1'b1, 4'hF, 1'b1, 2'd0, 7, 4'h0, 4'h0, 4'hF, 4'h0};

    for (int i = 0; i < 16; i++) begin
      rst = vt[i].rst; en = vt[i].en; cfg_we = vt[i].we; cfg_ch = vt[i].ch;
      cfg_period = cnt_t'(vt[i].per); err_clr = vt[i].clr;
      step();
      check($sformatf("vec%0d_tick", i), tick, vt[i].e_tick);
      check($sformatf("vec%0d_in_win", i), in_win, vt[i].e_win);
      check($sformatf("vec%0d_err", i), err, vt[i].e_err);
    end

    // Default period after a reset that collided with a write: ticks at 15001 and 30002.
    idle_inputs();
    en = 4'b0001;
    first_t = 0; second_t = 0; n_t = 0; other_t = 0;
    for (int k = 1; k <= 40000; k++) begin
      step();
      if (tick[0] === 1'b1) begin
        n_t++;
        if (n_t == 1) first_t = k;
        if (n_t == 2) second_t = k;
      end
      if (tick[3:1] !== 3'b000) other_t++;
    end
    check_int("default_first_tick", first_t, 15001);
    check_int("default_second_tick", second_t, 30002);
    check_int("default_tick_count", n_t, 2);
    check_int("default_other_ticks", other_t, 0);
    check("default_err", err, 4'h0);

    // Period 3 on ch1: tick every 4 cycles
    idle_inputs();
    step();
    write_period(1, 3);
    en = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("p3_tick_k%0d", k), {3'b000, tick[1]}, {3'b000, (k % 4 == 0)});
    end

    // Shrinking ch2 period below its count sets err and restarts
    idle_inputs();
    step();
    write_period(2, 100);
    en = 4'b0100;
    for (int k = 0; k < 50; k++) step();
    write_period(2, 10);
    step();
    check("shrink_err_set", {3'b000, err[2]}, 4'h1);
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("shrink_tick_k%0d", k), {3'b000, tick[2]}, {3'b000, (k == 11)});
    end
    err_clr = 4'b0100;
    step();
    err_clr = 4'b0000;
    step();
    check("shrink_err_cleared", {3'b000, err[2]}, 4'h0);

    // Period 0 on ch3: tick every enabled cycle
    idle_inputs();
    step();
    write_period(3, 0);
    en = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      check("p0_tick", {3'b000, tick[3]}, 4'h1);
    end
    en = 4'b0000;
    step();
    check("p0_tick_off", {3'b000, tick[3]}, 4'h0);

    // Reset mid-count together with a ch0 write
    en = 4'b0001;
    for (int k = 0; k < 100; k++) step();
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = cnt_t'(5);
    step();
    check("rst_tick", tick, 4'h0);
    check("rst_in_win", in_win, 4'hF);
    check("rst_err", err, 4'h0);
    rst = 1'b0; cfg_we = 1'b0;
    first_t = 0;
    for (int k = 1; k <= 15001; k++) begin
      step();
      if (tick[0] === 1'b1 && first_t == 0) first_t = k;
    end
    check_int("rst_period_first_tick", first_t, 15001);

`ifdef DELAY_ONESHOT_EN
    idle_inputs();
    step();
    write_period(0, 5);
    oneshot = 4'b0001;
    en = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("os_tick_k%0d", k), {3'b000, tick[0]}, {3'b000, (k == 6)});
    end
    en = 4'b0000;
    step();
    en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("os_rearm_k%0d", k), {3'b000, tick[0]}, {3'b000, (k == 6)});
    end
    oneshot = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("os_resume_k%0d", k), {3'b000, tick[0]}, {3'b000, (k == 6 || k == 12)});
    end
`endif

    // Random traffic against the model
    idle_inputs();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = 2'($urandom);
      cfg_period = cnt_t'($urandom_range(0, 12));
      err_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
`ifdef DELAY_ONESHOT_EN
      if ($urandom_range(0, 31) == 0) oneshot = 4'($urandom);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_delay_timer.md
# multi_delay_timer

Multi-channel programmable delay timer, the parametrised successor of the single-channel fixed-period delay counter. Each of NCH channels counts clock cycles up to a runtime-programmable period, emits a one-cycle `tick` at terminal count, reports whether the counter is inside its valid window, and flags a sticky error if the counter is ever found beyond its period (e.g. after reprogramming to a smaller value). It sits beside the control FSMs as a shared timeout/pacing source and is a formal-benchmark target for liveness properties of the form "always eventually tick unless reset recurs".

## Interface
- NCH, 4, number of independent channels (1..16)
- CBITS, 14, counter and period width
- DEFAULT_PERIOD, 15000, per-channel period loaded at reset (must fit in CBITS)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  NCH  per-channel count enable
- cfg_we  input  1  period write strobe
- cfg_ch  input  $clog2(NCH) (min 1)  channel selected for write; out-of-range index ignored
- cfg_period  input  CBITS  new period value
- err_clr  input  NCH  per-channel sticky-error clear
- tick  output  NCH  one-cycle pulse at terminal count
- in_win  output  NCH  1 while channel counter <= its period
- err  output  NCH  sticky: counter observed > period

## Operation
- Per channel i: registers cnt[i] (CBITS), period[i] (CBITS), tick[i], in_win[i], err[i].
- Reset: cnt=0, period=DEFAULT_PERIOD, tick=0, in_win=1, err=0 on all channels.
- en[i]=0: cnt<=0, tick<=0, in_win<=1; err held.
- en[i]=1, cnt==period: cnt<=0, tick<=1.
- en[i]=1, cnt<period: cnt<=cnt+1, tick<=0.
- en[i]=1, cnt>period (only reachable via reprogramming): cnt<=0, tick<=0, err<=1.
- in_win registered from the next-state cnt compared against the period in effect that cycle.
- period=0: tick asserted every enabled cycle.
- Counter arithmetic is CBITS unsigned; no wrap possible since cnt never exceeds period when period is legal; period=2^CBITS-1 is legal.
- cfg_we: period[cfg_ch]<=cfg_period; the current cycle compares against the old period.
- err_clr[i] and err-set in same cycle: set wins.
- rst overrides all inputs, including cfg_we and en.

## Timing
- Enabled continuously from reset with period P: first tick in cycle P+1 after en first seen high, then every P+1 cycles.
- tick, in_win, err are registered; no combinational input-to-output paths.
- Period write effective from the cycle after cfg_we.
- en deassert mid-count: next cycle cnt=0; re-enable restarts full P+1 interval.

## Configuration
- DELAY_ONESHOT_EN defined: adds input `oneshot` (NCH). A channel with oneshot[i]=1 stops after its first tick (cnt held 0, tick 0, in_win 1) until en[i] is seen low, which re-arms it. oneshot sampled each cycle; clearing it while halted resumes periodic counting next cycle.
- Undefined: port absent, all channels periodic only.

## Structure
- Package delay_timer_pkg: DEFAULT_PERIOD default constant, CBITS default, typedef cnt_t (logic [CBITS-1:0]).
- One sub-module delay_timer_chan (single channel: counter, period reg, tick/in_win/err), instantiated NCH times by generate; top decodes cfg_ch into per-channel write enables.

## Test plan
- NCH=4, CBITS=14, reset then en=4'b0001 for 40000 cycles -> tick[0] at cycles 15001, 30002; tick[3:1]=0; err=0.
- Write period 3 to ch1, en[1]=1 -> tick[1] every 4 cycles; in_win[1]=1 throughout.
- ch2 period 100, count to 50, write period 10 -> next cycle err[2]=1, cnt reset, tick[2] 11 cycles later; err_clr[2] pulse -> err[2]=0.
- period 0 on ch3 with en -> tick[3]=1 every cycle; deassert en[3] -> tick[3]=0 next cycle.
- rst asserted mid-count together with cfg_we to ch0 -> period[0]=15000, cnt=0, all outputs at reset values.
- DELAY_ONESHOT_EN, ch0 period 5, oneshot[0]=1 -> single tick at cycle 6, none after; en[0] low one cycle then high -> one more tick 6 cycles later.
